// File: rtl/prediction_table_write_scheduler.sv
// Single write-port scheduler for the branch prediction table: wr2 always wins,
// wr1 is buffered and drained on idle cycles, and a full clear sweep follows reset or flush.
module prediction_table_write_scheduler #(
    parameter int INDEX_WIDTH = 12,
    parameter int JUMP_STATUS_COUNTER_WIDTH = 2,
    parameter logic [JUMP_STATUS_COUNTER_WIDTH-1:0] JUMP_STATUS_COUNTER_INIT_VALUE = '0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_req,
    input  logic                                 wr1_en,
    input  logic [INDEX_WIDTH-1:0]               wr1_index,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] wr1_count,
    input  logic                                 wr2_en,
    input  logic [INDEX_WIDTH-1:0]               wr2_index,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] wr2_count,
    output logic                                 tbl_wr_en,
    output logic [INDEX_WIDTH-1:0]               tbl_wr_index,
    output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] tbl_wr_count,
    output logic                                 stall_req,
    output logic                                 flush_busy,
    output logic                                 flush_done,
    output logic                                 overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_HIGH = OCC_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic {ST_FLUSH, ST_RUN} state_t;

    state_t                                 state_q, state_d;
    logic [INDEX_WIDTH-1:0]                 sweep_q, sweep_d;
    logic [INDEX_WIDTH-1:0]                 fifo_idx_q [FIFO_DEPTH];
    logic [JUMP_STATUS_COUNTER_WIDTH-1:0]   fifo_cnt_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]                  fifo_vld_q, fifo_vld_d;
    logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]                       occ_q, occ_d;
    logic                                   overflow_d;

    logic                                   vld_p0;
    logic [INDEX_WIDTH-1:0]                 idx_p0;
    logic [JUMP_STATUS_COUNTER_WIDTH-1:0]   cnt_p0;
    logic                                   stall_p0, busy_p0, done_p0;
    logic                                   push_req, push_ok, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        fifo_vld_d = fifo_vld_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow;
        vld_p0     = 1'b0;
        idx_p0     = '0;
        cnt_p0     = '0;
        stall_p0   = 1'b0;
        busy_p0    = 1'b0;
        done_p0    = 1'b0;
        push_req   = 1'b0;
        push_ok    = 1'b0;
        pop        = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                busy_p0    = 1'b1;
                stall_p0   = 1'b1;
                vld_p0     = 1'b1;
                cnt_p0     = JUMP_STATUS_COUNTER_INIT_VALUE;
                fifo_vld_d = '0;
                rd_ptr_d   = '0;
                wr_ptr_d   = '0;
                occ_d      = '0;
                overflow_d = 1'b0;
                if (flush_req) begin
                    // Restart: this cycle's write becomes index 0 again.
                    idx_p0  = '0;
                    sweep_d = INDEX_WIDTH'(1);
                end else begin
                    idx_p0  = sweep_q;
                    sweep_d = sweep_q + INDEX_WIDTH'(1);
                    if (&sweep_q) begin
                        state_d = ST_RUN;
                        busy_p0 = 1'b0;
                        done_p0 = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (flush_req) begin
                    state_d    = ST_FLUSH;
                    sweep_d    = '0;
                    fifo_vld_d = '0;
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    occ_d      = '0;
                    overflow_d = 1'b0;
                    busy_p0    = 1'b1;
                    stall_p0   = 1'b1;
                end else begin
                    if (wr2_en) begin
                        vld_p0 = 1'b1;
                        idx_p0 = wr2_index;
                        cnt_p0 = wr2_count;
                        for (int i = 0; i < FIFO_DEPTH; i++) begin
                            if (fifo_idx_q[i] == wr2_index) fifo_vld_d[i] = 1'b0;
                        end
                        push_req = wr1_en && (wr1_index != wr2_index);
                    end else if (occ_q != '0) begin
                        // Cancelled heads still consume a drain slot but issue nothing.
                        pop        = 1'b1;
                        vld_p0     = fifo_vld_q[rd_ptr_q];
                        idx_p0     = fifo_idx_q[rd_ptr_q];
                        cnt_p0     = fifo_cnt_q[rd_ptr_q];
                        fifo_vld_d[rd_ptr_q] = 1'b0;
                        rd_ptr_d   = ptr_inc(rd_ptr_q);
                        push_req   = wr1_en;
                    end else if (wr1_en) begin
                        vld_p0 = 1'b1;
                        idx_p0 = wr1_index;
                        cnt_p0 = wr1_count;
                    end

                    if (push_req) begin
                        for (int i = 0; i < FIFO_DEPTH; i++) begin
                            if (fifo_idx_q[i] == wr1_index) fifo_vld_d[i] = 1'b0;
                        end
                    end
                    push_ok = push_req && ((occ_q != OCC_FULL) || pop);
                    if (push_ok) begin
                        fifo_vld_d[wr_ptr_q] = 1'b1;
                        wr_ptr_d             = ptr_inc(wr_ptr_q);
                    end
                    if (push_req && !push_ok) overflow_d = 1'b1;
                    occ_d    = occ_q + OCC_W'(push_ok) - OCC_W'(pop);
                    stall_p0 = (occ_d >= OCC_HIGH);
                end
            end

            default: ;
        endcase
    end

    // Stage p0 -> p1: selected write and status flags are registered onto the table port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FLUSH;
            sweep_q      <= '0;
            fifo_vld_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            overflow     <= 1'b0;
            tbl_wr_en    <= 1'b0;
            tbl_wr_index <= '0;
            tbl_wr_count <= '0;
            stall_req    <= 1'b1;
            flush_busy   <= 1'b1;
            flush_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            fifo_vld_q   <= fifo_vld_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            overflow     <= overflow_d;
            tbl_wr_en    <= vld_p0;
            tbl_wr_index <= idx_p0;
            tbl_wr_count <= cnt_p0;
            stall_req    <= stall_p0;
            flush_busy   <= busy_p0;
            flush_done   <= done_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_idx_q[wr_ptr_q] <= wr1_index;
            fifo_cnt_q[wr_ptr_q] <= wr1_count;
        end
    end

endmodule

// File: tb/tb_prediction_table_write_scheduler.sv
// Scoreboard bench for prediction_table_write_scheduler: expected table writes are
// queued with their due cycle when stimulus is driven and compared as the DUT emits them.
module tb_prediction_table_write_scheduler;

    localparam int IW    = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 4;
    localparam logic [CW-1:0] INIT = 2'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_req = 1'b0;
    logic          wr1_en = 1'b0;
    logic [IW-1:0] wr1_index = '0;
    logic [CW-1:0] wr1_count = '0;
    logic          wr2_en = 1'b0;
    logic [IW-1:0] wr2_index = '0;
    logic [CW-1:0] wr2_count = '0;
    logic          tbl_wr_en;
    logic [IW-1:0] tbl_wr_index;
    logic [CW-1:0] tbl_wr_count;
    logic          stall_req, flush_busy, flush_done, overflow;

    prediction_table_write_scheduler #(
        .INDEX_WIDTH(IW),
        .JUMP_STATUS_COUNTER_WIDTH(CW),
        .JUMP_STATUS_COUNTER_INIT_VALUE(INIT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req),
        .wr1_en(wr1_en), .wr1_index(wr1_index), .wr1_count(wr1_count),
        .wr2_en(wr2_en), .wr2_index(wr2_index), .wr2_count(wr2_count),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_index(tbl_wr_index), .tbl_wr_count(tbl_wr_count),
        .stall_req(stall_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
    } exp_wr_t;

    exp_wr_t sb_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input int due, input logic [IW-1:0] idx, input logic [CW-1:0] cnt);
        exp_wr_t e;
        e.due = due;
        e.idx = idx;
        e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic exp_sweep(input int base, input int n);
        for (int i = 0; i < n; i++) exp_wr(base + i, IW'(i), INIT);
    endtask

    task automatic drive(input logic w1e, input int w1i, input int w1c,
                         input logic w2e, input int w2i, input int w2c);
        wr1_en    = w1e;
        wr1_index = IW'(w1i);
        wr1_count = CW'(w1c);
        wr2_en    = w2e;
        wr2_index = IW'(w2i);
        wr2_count = CW'(w2c);
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 0, 0);
        flush_req = 1'b0;
    endtask

    // Write-port monitor: every cycle is either a due scoreboard write or must be idle.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            check_eq("wr_en", tbl_wr_en, 1);
            check_eq("wr_index", tbl_wr_index, sb_q[0].idx);
            check_eq("wr_count", tbl_wr_count, sb_q[0].cnt);
            void'(sb_q.pop_front());
        end else begin
            check_eq("wr_idle", tbl_wr_en, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f;
        int base;

        // Reset values
        repeat (3) tick();
        check_eq("rst_wr_en", tbl_wr_en, 0);
        check_eq("rst_wr_index", tbl_wr_index, 0);
        check_eq("rst_wr_count", tbl_wr_count, 0);
        check_eq("rst_stall", stall_req, 1);
        check_eq("rst_busy", flush_busy, 1);
        check_eq("rst_done", flush_done, 0);
        check_eq("rst_overflow", overflow, 0);

        // Post-reset sweep: index i lands on the port i+1 cycles after release
        rst = 1'b0;
        exp_sweep(cyc + 1, 16);
        for (int j = 1; j <= 16; j++) begin
            tick();
            check_eq("sweep_done", flush_done, (j == 16));
            check_eq("sweep_busy", flush_busy, (j < 16));
            check_eq("sweep_stall", stall_req, 1);
        end
        tick();
        check_eq("run_stall", stall_req, 0);
        check_eq("run_busy", flush_busy, 0);
        check_eq("run_done", flush_done, 0);

        // wr2 issued now, wr1 buffered and drained next cycle
        drive(1'b1, 5, 0, 1'b1, 3, 2);
        exp_wr(cyc + 1, 3, 2);
        exp_wr(cyc + 2, 5, 0);
        tick();
        check_eq("one_entry_stall", stall_req, 0);
        idle();
        repeat (3) tick();

        // Same-index conflict: only wr2 lands, FIFO stays empty so wr1 then bypasses
        drive(1'b1, 7, 0, 1'b1, 7, 3);
        exp_wr(cyc + 1, 7, 3);
        tick();
        idle();
        tick();
        drive(1'b1, 8, 1, 1'b0, 0, 0);
        exp_wr(cyc + 1, 8, 1);
        tick();
        idle();
        repeat (2) tick();

        // Buffered wr1 idx 9 cancelled by a later wr2 to idx 9
        drive(1'b1, 9, 1, 1'b1, 1, 0);
        exp_wr(cyc + 1, 1, 0);
        tick();
        drive(1'b1, 10, 2, 1'b1, 2, 1);
        exp_wr(cyc + 1, 2, 1);
        tick();
        drive(1'b0, 0, 0, 1'b1, 9, 2);
        exp_wr(cyc + 1, 9, 2);
        tick();
        idle();
        tick();
        exp_wr(cyc + 1, 10, 2);
        tick();
        repeat (2) tick();

        // A newer wr1 push cancels an older buffered wr1 to the same index
        drive(1'b1, 4, 1, 1'b1, 3, 0);
        exp_wr(cyc + 1, 3, 0);
        tick();
        drive(1'b1, 4, 3, 1'b1, 5, 1);
        exp_wr(cyc + 1, 5, 1);
        tick();
        idle();
        tick();
        exp_wr(cyc + 1, 4, 3);
        tick();
        repeat (2) tick();

        // Fill the FIFO under a wr2 stream: almost-full stall, then overflow on the 5th push
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8 + i, 3, 1'b1, i, i);
            exp_wr(cyc + 1, IW'(i), CW'(i));
            tick();
            check_eq("fill_stall", stall_req, (i >= 2));
            check_eq("fill_overflow", overflow, (i == 4));
        end
        idle();
        exp_wr(cyc + 1, 8, 3);
        tick();
        check_eq("drain_stall", stall_req, 1);
        check_eq("drain_overflow", overflow, 1);

        // flush_req in RUN with 3 entries pending: wr1/wr2 ignored, FIFO discarded
        drive(1'b1, 7, 2, 1'b1, 6, 1);
        flush_req = 1'b1;
        f = cyc;
        tick();
        idle();
        check_eq("flush_overflow_clr", overflow, 0);
        check_eq("flush_busy", flush_busy, 1);
        check_eq("flush_stall", stall_req, 1);
        check_eq("flush_no_done", flush_done, 0);
        exp_sweep(f + 2, 10);
        for (int j = 0; j < 10; j++) begin
            if (j == 3) drive(1'b1, 13, 2, 1'b1, 12, 2);
            tick();
            idle();
            check_eq("partial_done", flush_done, 0);
            check_eq("partial_busy", flush_busy, 1);
        end

        // Restart the sweep when index 10 is about to be issued
        flush_req = 1'b1;
        base = cyc + 1;
        exp_sweep(base, 16);
        tick();
        flush_req = 1'b0;
        check_eq("restart_done", flush_done, 0);
        for (int j = 1; j <= 15; j++) begin
            tick();
            check_eq("restart_done", flush_done, (j == 15));
            check_eq("restart_busy", flush_busy, (j < 15));
            check_eq("restart_stall", stall_req, 1);
        end
        tick();
        check_eq("restart_run_stall", stall_req, 0);
        repeat (6) tick();

        check_eq("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
